keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 passive key matrix by driving one column low at a time and reading the rows.
- Synchronizes and debounces the whole matrix, then reports each newly pressed key as a 4-bit code over a valid/ready handshake.
- Input-side counterpart of the multiplexed LED matrix driver: same scanned-matrix technique, opposite signal direction.
- Feeds the digit/counter logic that currently free-runs.

Parameters:
SCAN_DIV, 6000, CLK cycles each column is driven (0.5 ms at 12 MHz); must be >= 4.
DEBOUNCE_SCANS, 8, consecutive identical full-matrix frames required before the debounced state updates; must be >= 1.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST  input  1  synchronous reset, active-high.
COL  output  4  column drive, active-low, exactly one bit low at any time.
ROW  input  4  row sense, active-low (external pull-ups), asynchronous.
KEY_CODE  output  4  code of reported key = col*4 + row.
KEY_VALID  output  1  KEY_CODE holds an unconsumed press event.
KEY_READY  input  1  consumer accepts the event when high with KEY_VALID.
PRESSED  output  1  high while any key is held in the debounced state.
OVERRUN  output  1  sticky: a press event was dropped.

Behaviour:
- Reset values: COL=4'b1110, KEY_CODE=0, KEY_VALID=0, PRESSED=0, OVERRUN=0. Internal state also clears: divider, column index, raw frame, previous frame, stable count, debounced state.
- RST asserted mid-operation clears everything on that edge. Any pending event is discarded.
- ROW passes through a 2-flop synchronizer. Each bit is inverted so that 1 means pressed.
- Divider counts 0..SCAN_DIV-1 per column.
- On divider == SCAN_DIV-1:
  - The synchronized rows are written into raw frame bits [col*4+3 : col*4].
  - The column index advances 0->1->2->3->0.
  - COL updates on the next cycle: 1110, 1101, 1011, 0111.
- A frame is complete on the column-3 sample.
- At frame completion, debounce:
  - If the new frame equals the previous frame, the stable count increments, saturating at DEBOUNCE_SCANS. Otherwise the stable count resets to 0.
  - Previous frame is then loaded with the new frame.
  - When the stable count becomes equal to DEBOUNCE_SCANS (transition only), the debounced state loads the frame.
- PRESSED = OR of the debounced state, registered. It updates with the debounced state.
- Event generation:
  - new_press = debounced_next AND NOT debounced_current.
  - If non-zero, the lowest set index is the event. Other simultaneous new presses are discarded; they are not queued.
  - Releases generate no event.
- Event latency: KEY_VALID/KEY_CODE update on the cycle after the frame-completing sample.
- Handshake:
  - KEY_VALID stays high and KEY_CODE stays stable until a cycle with KEY_VALID && KEY_READY.
  - On acceptance with no new event, KEY_VALID falls on the next cycle.
- Simultaneous acceptance and new event: the new code loads, KEY_VALID stays 1, OVERRUN is unchanged.
- New event while KEY_VALID=1 and not accepted that cycle: the event is dropped, KEY_CODE is unchanged, OVERRUN=1 until RST.
- KEY_READY while KEY_VALID=0 has no effect.
- Divider and column index wrap freely. Scanning never stalls, independent of the handshake.

Test Plan:
- Bench uses SCAN_DIV=8, DEBOUNCE_SCANS=3, so a frame is 32 cycles.
- Column walk, no keys: after RST, COL = 1110, 1101, 1011, 0111, each for exactly 8 cycles, then repeats. KEY_VALID and PRESSED stay 0 for 1000 cycles.
- Single press: model drives ROW[1] low only while COL[2] is low, held steady, KEY_READY=0. KEY_VALID rises with KEY_CODE=9 and PRESSED=1 at the end of the 4th complete frame containing the key (+1 cycle). Then assert KEY_READY for one cycle: KEY_VALID falls next cycle. Release the key: PRESSED falls after 4 frames and no new event appears.
- Bounce: toggle key 9 every 5 cycles for 150 cycles, then hold. Exactly one event with code 9, no OVERRUN.
- Simultaneous keys: keys 2 (col0,row2) and 7 (col1,row3) pressed in the same cycle. A single event with code 2 is produced and key 7 is never reported while held.
- Overrun: KEY_READY=0; press/release key 5, then press key 12 after key 5 has debounced released. KEY_CODE stays 5 and OVERRUN=1. KEY_READY for one cycle, then KEY_VALID=0 and OVERRUN stays 1.
- Reset mid-event: with KEY_VALID=1 (code 9), pulse RST for one cycle. Next cycle all outputs are at reset values, COL=1110, and a fresh event for the still-held key appears after 4 frames.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: walks one active-low column at a time, samples the
// synchronized rows into a full-matrix frame, debounces whole frames and
// reports each newly pressed key as a code over a valid/ready handshake.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 6000,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] COL,
    input  logic [3:0] ROW,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_READY,
    output logic       PRESSED,
    output logic       OVERRUN
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS);

    logic [3:0]      row_meta_q;
    logic [3:0]      row_sync_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_idx_q;
    logic [3:0]      col_q;
    logic [15:0]     raw_frame_q;
    logic [15:0]     prev_frame_q;
    logic [CntW-1:0] stable_cnt_q;
    logic [15:0]     debounced_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            pressed_q;
    logic            overrun_q;

    logic [3:0]      rows_now;
    logic            sample;
    logic            frame_done;
    logic [1:0]      col_idx_d;
    logic [15:0]     frame_new;
    logic [CntW-1:0] stable_cnt_d;
    logic            load_deb;
    logic [15:0]     debounced_d;
    logic [15:0]     new_press;
    logic            have_event;
    logic [3:0]      event_code;
    logic            accept;

    assign COL       = col_q;
    assign KEY_CODE  = key_code_q;
    assign KEY_VALID = key_valid_q;
    assign PRESSED   = pressed_q;
    assign OVERRUN   = overrun_q;

    // Frame assembly, debounce decision and press-event extraction.
    always_comb begin
        rows_now   = ~row_sync_q;
        sample     = (div_q == DivLast);
        frame_done = sample && (col_idx_q == 2'd3);
        col_idx_d  = col_idx_q + 2'd1;

        // Frame as it stands with the current column's rows merged in.
        frame_new = raw_frame_q;
        frame_new[{col_idx_q, 2'b00} +: 4] = rows_now;

        if (frame_new == prev_frame_q) begin
            stable_cnt_d = (stable_cnt_q == CntMax) ? stable_cnt_q : stable_cnt_q + CntW'(1);
        end else begin
            stable_cnt_d = '0;
        end

        // Load only on the transition into the stable state.
        load_deb    = frame_done && (stable_cnt_d == CntMax) && (stable_cnt_q != CntMax);
        debounced_d = load_deb ? frame_new : debounced_q;
        new_press   = debounced_d & ~debounced_q;
        have_event  = |new_press;

        // Lowest set index wins; other simultaneous presses are dropped.
        event_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (new_press[i]) begin
                event_code = 4'(i);
            end
        end

        accept = key_valid_q && KEY_READY;
    end

    // All sequential state: synchronizer, scan, debounce and handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            div_q        <= '0;
            col_idx_q    <= 2'd0;
            col_q        <= 4'b1110;
            raw_frame_q  <= '0;
            prev_frame_q <= '0;
            stable_cnt_q <= '0;
            debounced_q  <= '0;
            key_code_q   <= 4'd0;
            key_valid_q  <= 1'b0;
            pressed_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;

            if (sample) begin
                div_q       <= '0;
                col_idx_q   <= col_idx_d;
                col_q       <= ~(4'b0001 << col_idx_d);
                raw_frame_q <= frame_new;
            end else begin
                div_q <= div_q + DivW'(1);
            end

            if (frame_done) begin
                stable_cnt_q <= stable_cnt_d;
                prev_frame_q <= frame_new;
                debounced_q  <= debounced_d;
                pressed_q    <= |debounced_d;
            end

            if (have_event) begin
                if (!key_valid_q || accept) begin
                    key_code_q  <= event_code;
                    key_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                key_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural key matrix.
// SCAN_DIV=8, DEBOUNCE_SCANS=3: one frame is 32 cycles, an event appears
// 128 cycles after the start of the first frame that holds the key.
module tb_keypad_matrix_scanner;

    localparam int unsigned ScanDiv = 8;
    localparam int unsigned DebScans = 3;
    localparam int Frame = 32;

    logic       clk;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       pressed;
    logic       overrun;

    logic [15:0] keys;
    int          checks = 0;
    int          errors = 0;
    int          ev_count = 0;
    logic [3:0]  ev_last = 4'd0;
    int          base;
    logic        bad;
    logic [3:0]  exp_col;

    keypad_matrix_scanner #(
        .SCAN_DIV       (ScanDiv),
        .DEBOUNCE_SCANS (DebScans)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .COL       (col),
        .ROW       (row),
        .KEY_CODE  (key_code),
        .KEY_VALID (key_valid),
        .KEY_READY (key_ready),
        .PRESSED   (pressed),
        .OVERRUN   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    // Consumer-side record of accepted events.
    always @(posedge clk) begin
        if (key_valid && key_ready) begin
            ev_count <= ev_count + 1;
            ev_last  <= key_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Land on the first cycle of a frame (first negedge with column 0 driven).
    task automatic align();
        int n;
        n = 0;
        while (col !== 4'b0111 && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (col !== 4'b1110 && n < 128) begin
            @(negedge clk);
            n++;
        end
        chk("align_col0", 32'(col), 32'h0000_000E);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"},     32'(col),       32'hE);
        chk({tag, "_code"},    32'(key_code),  32'h0);
        chk({tag, "_valid"},   32'(key_valid), 32'h0);
        chk({tag, "_pressed"}, 32'(pressed),   32'h0);
        chk({tag, "_overrun"}, 32'(overrun),   32'h0);
    endtask

    initial begin
        keys      = 16'h0000;
        key_ready = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Column walk: each column low for exactly 8 cycles, then repeat.
        for (int i = 0; i < 64; i++) begin
            exp_col = ~(4'b0001 << ((i / 8) % 4));
            chk("col_walk", 32'(col), 32'(exp_col));
            @(negedge clk);
        end

        // Idle matrix: no events and nothing pressed.
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (key_valid !== 1'b0 || pressed !== 1'b0) bad = 1'b1;
        end
        chk("idle_quiet", 32'(bad), 32'h0);

        // Single press of key 9 (col 2, row 1), exact latency.
        align();
        keys = 16'h0200;
        wait_cycles(127);
        chk("press_early_valid", 32'(key_valid), 32'h0);
        @(negedge clk);
        chk("press_valid",   32'(key_valid), 32'h1);
        chk("press_code",    32'(key_code),  32'h9);
        chk("press_pressed", 32'(pressed),   32'h1);
        wait_cycles(20);
        chk("press_hold_valid", 32'(key_valid), 32'h1);
        chk("press_hold_code",  32'(key_code),  32'h9);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        chk("accept_valid_falls", 32'(key_valid), 32'h0);
        chk("accept_pressed",     32'(pressed),   32'h1);

        // Release: PRESSED falls after 4 frames, no event.
        align();
        keys = 16'h0000;
        wait_cycles(127);
        chk("release_early_pressed", 32'(pressed), 32'h1);
        @(negedge clk);
        chk("release_pressed", 32'(pressed),   32'h0);
        chk("release_valid",   32'(key_valid), 32'h0);

        // Bounce on key 9, then hold: exactly one event.
        key_ready = 1'b1;
        base = ev_count;
        align();
        for (int t = 0; t < 150; t++) begin
            keys[9] = ((t / 5) % 2 == 0);
            @(negedge clk);
        end
        keys[9] = 1'b1;
        wait_cycles(6 * Frame);
        chk("bounce_events",  32'(ev_count - base), 32'd1);
        chk("bounce_code",    32'(ev_last),         32'h9);
        chk("bounce_overrun", 32'(overrun),         32'h0);
        chk("bounce_pressed", 32'(pressed),         32'h1);
        keys = 16'h0000;
        wait_cycles(6 * Frame);
        chk("bounce_rel_pressed", 32'(pressed),         32'h0);
        chk("bounce_rel_events",  32'(ev_count - base), 32'd1);

        // Keys 2 and 7 pressed together: only 2 is reported.
        base = ev_count;
        align();
        keys = 16'h0084;
        wait_cycles(6 * Frame);
        chk("simul_events",  32'(ev_count - base), 32'd1);
        chk("simul_code",    32'(ev_last),         32'h2);
        chk("simul_pressed", 32'(pressed),         32'h1);
        wait_cycles(4 * Frame);
        chk("simul_no_key7", 32'(ev_count - base), 32'd1);
        chk("simul_valid",   32'(key_valid),       32'h0);
        keys = 16'h0000;
        wait_cycles(6 * Frame);
        key_ready = 1'b0;

        // Overrun: key 5 unconsumed, then key 12 arrives and is dropped.
        align();
        keys = 16'h0020;
        wait_cycles(6 * Frame);
        chk("ovr_k5_valid",   32'(key_valid), 32'h1);
        chk("ovr_k5_code",    32'(key_code),  32'h5);
        chk("ovr_k5_overrun", 32'(overrun),   32'h0);
        keys = 16'h0000;
        wait_cycles(6 * Frame);
        chk("ovr_rel_pressed", 32'(pressed),   32'h0);
        chk("ovr_rel_code",    32'(key_code),  32'h5);
        keys = 16'h1000;
        wait_cycles(6 * Frame);
        chk("ovr_valid",   32'(key_valid), 32'h1);
        chk("ovr_code",    32'(key_code),  32'h5);
        chk("ovr_overrun", 32'(overrun),   32'h1);
        chk("ovr_pressed", 32'(pressed),   32'h1);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        chk("ovr_accept_valid",  32'(key_valid), 32'h0);
        chk("ovr_sticky",        32'(overrun),   32'h1);
        keys = 16'h0000;
        wait_cycles(6 * Frame);

        // Reset while an event for key 9 is pending.
        keys = 16'h0200;
        wait_cycles(6 * Frame);
        chk("rst_pre_valid", 32'(key_valid), 32'h1);
        chk("rst_pre_code",  32'(key_code),  32'h9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("midrst");
        wait_cycles(127);
        chk("midrst_early_valid", 32'(key_valid), 32'h0);
        @(negedge clk);
        chk("midrst_valid",   32'(key_valid), 32'h1);
        chk("midrst_code",    32'(key_code),  32'h9);
        chk("midrst_pressed", 32'(pressed),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
